mcore_mem_arbiter: RTL and testbench
====================================

# mcore_mem_arbiter

Round-robin arbiter that shares the single mcore external memory port (req/gnt/rsp_valid request-response interface) between `NUM_REQ` internal requesters: texel/PDATA fetch, framebuffer read-modify-write and PLUT/CCB loader. It tracks outstanding transactions in an in-order ID FIFO so that each response returns to the requester that issued it. It sits between the cel engine clients and the `mem_*` ports of `mcore_top_wrapper`.

## Interface
- `DATA_WIDTH`, 32, data bus width.
- `ADDR_WIDTH`, 32, address bus width.
- `NUM_REQ`, 3, number of requesters (2..8).
- `MAX_OUTSTANDING`, 4, depth of the outstanding-ID FIFO (power of two, 2..16).
---
- `aclk  in  1`  single clock, rising edge.
- `aresetn  in  1`  asynchronous, active-low reset.
- `s_req  in  NUM_REQ`  per-requester request.
- `s_addr  in  NUM_REQ*ADDR_WIDTH`  packed addresses, requester i at slice i.
- `s_we  in  NUM_REQ`  write enable.
- `s_wdata  in  NUM_REQ*DATA_WIDTH`  packed write data.
- `s_be  in  NUM_REQ*DATA_WIDTH/8`  packed byte enables.
- `s_gnt  out  NUM_REQ`  one-hot grant.
- `s_rsp_valid  out  NUM_REQ`  one-hot response strobe.
- `s_rsp_rdata  out  DATA_WIDTH`  response data, broadcast to all requesters.
- `s_rsp_error  out  1`  response error, broadcast to all requesters.
- `mem_req  out  1`, `mem_addr  out  ADDR_WIDTH`, `mem_we  out  1`, `mem_wdata  out  DATA_WIDTH`, `mem_be  out  DATA_WIDTH/8`  downstream request.
- `mem_gnt  in  1`, `mem_rsp_valid  in  1`, `mem_rsp_rdata  in  DATA_WIDTH`, `mem_rsp_error  in  1`  downstream grant and response.
- `busy  out  1`  high while the FIFO is non-empty or any `s_req` is high.
- `err_unexp_rsp  out  1`  sticky; set by a response that arrives while the FIFO is empty.

## Operation
**Protocol**
- A requester holds `req` and its address, data and control stable until its `gnt` arrives.
- Handshake occurs on a cycle with `mem_req & mem_gnt`.
- Every accepted transaction, read or write, yields exactly one `mem_rsp_valid`.
- Responses return in order.

**Arbitration**
- Round-robin pointer `rr_ptr` (reset 0).
- When unlocked, `sel` is the first asserted `s_req` searching from `rr_ptr` upward, with wrap-around.
- `mem_*` request fields are muxed from `sel`.
- `mem_req = |s_req & ~fifo_full`.
- `s_gnt[sel] = mem_gnt & mem_req`. All other grant bits are 0.

**Lock**
- If `mem_req` is high and `mem_gnt` is low, `lock` is set and `sel` is registered.
- Once locked, `sel` does not change until the handshake, even if a higher-priority request appears.

**Handshake**
- `rr_ptr <= (sel+1) mod NUM_REQ`.
- `lock` clears.
- `sel` is pushed into the ID FIFO.

**Response**
- `s_rsp_valid[fifo_head] = mem_rsp_valid & ~fifo_empty`.
- `s_rsp_rdata` and `s_rsp_error` are passthrough.
- Each response pops the FIFO.

**Boundary conditions**
- FIFO full: `mem_req` is forced low, no grant is issued, and `lock` is held. This applies even if a pop occurs in the same cycle; a pop does not free a slot until the next cycle.
- Push and pop in the same cycle (not full): count is unchanged and both pointers advance.
- Response while FIFO empty: the response is dropped, no `s_rsp_valid` is asserted, and `err_unexp_rsp` is set. It clears only on reset.
- Requester deasserts `req` while locked: protocol violation. Behaviour is unspecified; an SVA flags it.
- Reset mid-operation: FIFO, `lock`, `rr_ptr` and the sticky flag are cleared. In-flight responses arriving after reset count as unexpected.

## Timing
- Request path is combinational, 0 cycles: `s_req` to `mem_req`, and `mem_gnt` to `s_gnt`.
- Response path is combinational, 0 cycles: `mem_rsp_valid` to `s_rsp_valid`.
- Back-to-back handshakes run at 1 per cycle. Fairness is exact rotation among active requesters.
- Reset values: `s_gnt=0`, `s_rsp_valid=0`, `mem_req=0`, `busy=0`, `err_unexp_rsp=0`.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` reset to 0 (mux of requester 0 with `s_req=0` is don't-care but must not be X).
- FIFO count is `$clog2(MAX_OUTSTANDING)+1` bits wide. Pointers wrap modulo `MAX_OUTSTANDING`.
- No combinational path exists from `mem_rsp_*` to `mem_req`.

## Test plan
- **Single read:** requester 1 reads 0x283B08 with `mem_gnt=1` and memory latency 2. Expect `s_gnt=3'b010` in cycle 0 and `s_rsp_valid=3'b010` in cycle 2 with the data from the memory model.
- **Round-robin:** all three `s_req` held for 6 grants with `mem_gnt=1`. Expect grant order 0,1,2,0,1,2 and one response per requester per round, in the same order.
- **Lock:** requester 2 requests and `mem_gnt` is held 0 for 3 cycles while requester 0 raises `req` in cycle 1. Expect `mem_addr` to stay at requester 2's address, the first grant to go to requester 2, and requester 0 to be granted next.
- **Outstanding limit:** with `MAX_OUTSTANDING=4`, issue 5 reads with the response delayed 10 cycles. Expect `mem_req=0` after the 4th handshake; the 5th is granted the cycle after the first response pops.
- **Unexpected response:** pulse `mem_rsp_valid` with the FIFO empty. Expect all `s_rsp_valid` low and `err_unexp_rsp=1` held until `aresetn=0`.
- **Mid-operation reset and end-to-end check:** reset with 3 outstanding, then replay the `draw_literal_1` cel memory image through the arbiter. Expect `busy=0` after reset and a memory compare with 0 errors.

Source files
------------

// File: rtl/mcore_mem_arbiter_if.sv
// Request/response bundle between the cel-engine clients and the single external
// memory port; the arbiter takes the master view, clients plus memory the slave view.
interface mcore_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 3
) ();
  logic [NUM_REQ-1:0]              s_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr;
  logic [NUM_REQ-1:0]              s_we;
  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_be;
  logic [NUM_REQ-1:0]              s_gnt;
  logic [NUM_REQ-1:0]              s_rsp_valid;
  logic [DATA_WIDTH-1:0]           s_rsp_rdata;
  logic                            s_rsp_error;

  logic                            mem_req;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_we;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH/8-1:0]         mem_be;
  logic                            mem_gnt;
  logic                            mem_rsp_valid;
  logic [DATA_WIDTH-1:0]           mem_rsp_rdata;
  logic                            mem_rsp_error;

  modport master (
    input  s_req, s_addr, s_we, s_wdata, s_be,
    input  mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error,
    output s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_be
  );

  modport slave (
    output s_req, s_addr, s_we, s_wdata, s_be,
    output mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error,
    input  s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_be
  );
endinterface

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NUM_REQ requesters;
// an ID FIFO of granted requester indices routes each response back to its issuer.
module mcore_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  mcore_mem_arbiter_if.master bus,
  output logic                busy,
  output logic                err_unexp_rsp
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel_lock, w_sel_lock_nxt;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   w_sel_search, w_sel;
  logic               w_found;
  logic [SEL_W-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;
  logic               w_full, w_empty, w_any_req, w_mem_req, w_push, w_pop;

  // First asserted request at or above the round-robin pointer, wrapping around.
  always_comb begin : p_search
    int idx;
    idx          = 0;
    w_sel_search = '0;
    w_found      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && bus.s_req[idx]) begin
        w_found      = 1'b1;
        w_sel_search = SEL_W'(idx);
      end
    end
  end

  assign w_sel     = (r_state == ST_LOCKED) ? r_sel_lock : w_sel_search;
  assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty   = (r_count == '0);
  assign w_any_req = |bus.s_req;
  // Fullness is the registered count only, so a same-cycle pop never frees a slot.
  assign w_mem_req = w_any_req & ~w_full;
  assign w_push    = w_mem_req & bus.mem_gnt;
  assign w_pop     = bus.mem_rsp_valid & ~w_empty;

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = bus.s_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_we      = bus.s_we[w_sel];
  assign bus.mem_wdata   = bus.s_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign bus.mem_be      = bus.s_be[w_sel*BE_W +: BE_W];
  assign bus.s_rsp_rdata = bus.mem_rsp_rdata;
  assign bus.s_rsp_error = bus.mem_rsp_error;

  always_comb begin
    bus.s_gnt = '0;
    if (w_push) bus.s_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    bus.s_rsp_valid = '0;
    if (w_pop) bus.s_rsp_valid[r_fifo[r_rd_ptr]] = 1'b1;
  end

  // A stalled request freezes the selection until it is accepted.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_lock_nxt = r_sel_lock;
    case (r_state)
      ST_OPEN: begin
        if (w_mem_req && !bus.mem_gnt) begin
          w_state_nxt    = ST_LOCKED;
          w_sel_lock_nxt = w_sel_search;
        end
      end
      ST_LOCKED: begin
        if (w_push) w_state_nxt = ST_OPEN;
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_OPEN;
      r_sel_lock <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel_lock <= w_sel_lock_nxt;
      if (w_push) r_rr_ptr <= (w_sel == SEL_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.mem_rsp_valid && w_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_sel;
  end

  assign busy          = ~w_empty | w_any_req;
  assign err_unexp_rsp = r_err;

  a_lock_req_held: assert property (@(posedge aclk) disable iff (!aresetn)
    (r_state == ST_LOCKED) |-> bus.s_req[r_sel_lock]);
endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Directed bench for mcore_mem_arbiter: in-order memory model, a queue-based
// reference of arbitration/ID routing checked every cycle, plus literal spot checks.
module tb_mcore_mem_arbiter;
  localparam int NR   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;

  logic aclk;
  logic aresetn;
  logic busy;
  logic err_unexp_rsp;

  mcore_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  mcore_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_OUTSTANDING(MAXO)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus.master), .busy(busy), .err_unexp_rsp(err_unexp_rsp)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  typedef struct { int due; logic [DW-1:0] data; } mrsp_t;
  mrsp_t          mq[$];
  logic [DW-1:0]  mem_arr [logic [AW-1:0]];
  int             mem_lat = 2;
  logic           m_valid = 1'b0;
  logic [DW-1:0]  m_rdata = '0;
  logic           inj_valid = 1'b0;
  logic           inj_err = 1'b0;
  logic [DW-1:0]  inj_rdata = '0;

  assign bus.mem_rsp_valid = m_valid | inj_valid;
  assign bus.mem_rsp_rdata = inj_valid ? inj_rdata : m_rdata;
  assign bus.mem_rsp_error = inj_valid & inj_err;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin : p_mem
    int c;
    logic [DW-1:0] w;
    c = 0;
    forever begin
      @(posedge aclk); #1;
      c++;
      if (!aresetn) mq.delete();
      if (aresetn && mq.size() > 0 && mq[0].due <= c) begin
        m_valid = 1'b1;
        m_rdata = mq[0].data;
      end else begin
        m_valid = 1'b0;
      end
      @(negedge aclk);
      if (!aresetn) mq.delete();
      else begin
        if (m_valid) void'(mq.pop_front());
        if (bus.mem_req && bus.mem_gnt) begin
          w = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : pat(bus.mem_addr);
          if (bus.mem_we) begin
            for (int b = 0; b < BW; b++)
              if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem_arr[bus.mem_addr] = w;
            mq.push_back('{due: c + mem_lat, data: '0});
          end else begin
            mq.push_back('{due: c + mem_lat, data: w});
          end
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int m_rr   = 0;
  int m_lock = -1;
  bit m_err  = 1'b0;
  int oq[$];

  always @(negedge aclk) begin : p_cmp
    int sel, idx;
    bit any, full, found, e_req;
    logic [NR-1:0] e_gnt, e_rv;
    if (!aresetn) begin
      oq.delete(); m_rr = 0; m_lock = -1; m_err = 1'b0;
    end
    any   = |bus.s_req;
    full  = (oq.size() == MAXO);
    sel   = 0;
    found = 1'b0;
    if (m_lock >= 0) sel = m_lock;
    else
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (!found && bus.s_req[idx]) begin found = 1'b1; sel = idx; end
      end
    e_req = any && !full;
    e_gnt = '0;
    if (e_req && bus.mem_gnt) e_gnt[sel] = 1'b1;
    e_rv = '0;
    if (bus.mem_rsp_valid && oq.size() > 0) e_rv[oq[0]] = 1'b1;
    chk("mem_req", bus.mem_req, e_req);
    chk("s_gnt", bus.s_gnt, e_gnt);
    chk("s_rsp_valid", bus.s_rsp_valid, e_rv);
    chk("s_rsp_rdata", bus.s_rsp_rdata, bus.mem_rsp_rdata);
    chk("s_rsp_error", bus.s_rsp_error, bus.mem_rsp_error);
    chk("busy", busy, (oq.size() > 0) || any);
    chk("err_unexp_rsp", err_unexp_rsp, m_err);
    if (e_req) begin
      chk("mem_addr", bus.mem_addr, bus.s_addr[sel*AW +: AW]);
      chk("mem_we", bus.mem_we, bus.s_we[sel]);
      chk("mem_wdata", bus.mem_wdata, bus.s_wdata[sel*DW +: DW]);
      chk("mem_be", bus.mem_be, bus.s_be[sel*BW +: BW]);
    end
    if (aresetn) begin
      if (bus.mem_rsp_valid) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else m_err = 1'b1;
      end
      if (e_req && bus.mem_gnt) begin
        oq.push_back(sel); m_rr = (sel + 1) % NR; m_lock = -1;
      end else if (e_req) m_lock = sel;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge aclk); #1; endtask
  task automatic settle(); @(negedge aclk); endtask

  task automatic drive_req(input int i, input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.s_addr[i*AW +: AW]  = a;
    bus.s_we[i]             = we;
    bus.s_wdata[i*DW +: DW] = d;
    bus.s_be[i*BW +: BW]    = be;
  endtask

  task automatic clear_inputs();
    bus.s_req = '0; bus.s_addr = '0; bus.s_we = '0; bus.s_wdata = '0; bus.s_be = '0;
    bus.mem_gnt = 1'b0;
  endtask

  task automatic do_reset();
    step(); aresetn = 1'b0; clear_inputs();
    step(); aresetn = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && busy; i++) step();
    settle();
    chk(nm, busy, 1'b0);
  endtask

  typedef struct { int id; logic [DW-1:0] data; } exp_t;
  logic [DW-1:0] img [9] = '{32'h0A0B_0C0D, 32'h1122_3344, 32'hCAFE_F00D, 32'h0000_FFFF,
                             32'h8000_0001, 32'h7E57_C0DE, 32'h1357_9BDF, 32'hFFFF_0000,
                             32'h0F1E_2D3C};

  // Three requesters stream their share of the image concurrently.
  task automatic xfer(input logic we, input string nm);
    int   nxt [NR];
    exp_t eq[$];
    exp_t e;
    logic [NR-1:0] ev;
    bit   fin;
    int   left;
    for (int i = 0; i < NR; i++) nxt[i] = i;
    fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (nxt[i] < 9) begin
          bus.s_req[i] = 1'b1;
          drive_req(i, 32'h0001_2000 + 32'(4*nxt[i]), we, img[nxt[i]], 4'hF);
        end else bus.s_req[i] = 1'b0;
      end
      settle();
      if (|bus.s_rsp_valid) begin
        if (eq.size() == 0) chk({nm, "_rsp_unexpected"}, bus.s_rsp_valid, '0);
        else begin
          e = eq.pop_front();
          ev = '0; ev[e.id] = 1'b1;
          chk({nm, "_rsp_id"}, bus.s_rsp_valid, ev);
          if (!we) chk({nm, "_rdata"}, bus.s_rsp_rdata, e.data);
        end
      end
      for (int i = 0; i < NR; i++)
        if (bus.s_gnt[i]) begin
          eq.push_back('{id: i, data: img[nxt[i]]});
          nxt[i] += NR;
        end
      fin = (nxt[0] >= 9) && (nxt[1] >= 9) && (nxt[2] >= 9) && (eq.size() == 0);
    end
    left = eq.size();
    for (int i = 0; i < NR; i++) if (nxt[i] < 9) left++;
    chk({nm, "_left"}, left, 0);
    step(); bus.s_req = '0;
  endtask

  // ---------------- directed sequence ----------------
  logic [NR-1:0] gnt_tab [9]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
  logic [NR-1:0] rsp_tab [9]  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic          mreq_tab [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : p_stim
    int n;
    aresetn = 1'b0;
    clear_inputs();
    settle();
    chk("rst_s_gnt", bus.s_gnt, '0);
    chk("rst_s_rsp_valid", bus.s_rsp_valid, '0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_unexp_rsp, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_mem_be", bus.mem_be, '0);
    step(); aresetn = 1'b1;

    // single read, latency 2
    mem_lat = 2;
    step(); bus.s_req = 3'b010; drive_req(1, 32'h0028_3B08, 1'b0, '0, 4'hF); bus.mem_gnt = 1'b1;
    settle(); chk("t1_gnt", bus.s_gnt, 3'b010);
    step(); bus.s_req = '0;
    settle(); chk("t1_rsp_c1", bus.s_rsp_valid, 3'b000);
    step();
    settle(); chk("t1_rsp_c2", bus.s_rsp_valid, 3'b010);
    chk("t1_rdata", bus.s_rsp_rdata, 32'h5A72_3B08);
    drain("t1_drain");

    // round robin, all requesters continuously active
    do_reset(); mem_lat = 3;
    for (int k = 0; k < 9; k++) begin
      step(); bus.s_req = (k < 6) ? 3'b111 : 3'b000; bus.mem_gnt = 1'b1;
      settle();
      chk($sformatf("t2_gnt_%0d", k), bus.s_gnt, gnt_tab[k]);
      chk($sformatf("t2_rsp_%0d", k), bus.s_rsp_valid, rsp_tab[k]);
    end
    drain("t2_drain");

    // lock holds the stalled requester's address
    do_reset(); mem_lat = 2;
    step(); bus.s_req = 3'b100; bus.mem_gnt = 1'b0;
    drive_req(2, 32'h0000_2200, 1'b0, '0, 4'hF); drive_req(0, 32'h0000_0A00, 1'b0, '0, 4'hF);
    settle(); chk("t3_addr_c0", bus.mem_addr, 32'h0000_2200); chk("t3_gnt_c0", bus.s_gnt, 3'b000);
    step(); bus.s_req = 3'b101;
    settle(); chk("t3_addr_c1", bus.mem_addr, 32'h0000_2200);
    step();
    settle(); chk("t3_addr_c2", bus.mem_addr, 32'h0000_2200);
    step(); bus.mem_gnt = 1'b1;
    settle(); chk("t3_gnt_first", bus.s_gnt, 3'b100);
    step(); bus.s_req = 3'b001;
    settle(); chk("t3_gnt_next", bus.s_gnt, 3'b001); chk("t3_addr_next", bus.mem_addr, 32'h0000_0A00);
    step(); bus.s_req = '0;
    drain("t3_drain");

    // outstanding limit
    do_reset(); mem_lat = 10; n = 0;
    for (int k = 0; k < 12; k++) begin
      step(); bus.s_req = 3'b001; bus.mem_gnt = 1'b1;
      drive_req(0, 32'h0000_1000 + 32'(4*n), 1'b0, '0, 4'hF);
      settle();
      chk($sformatf("t4_mem_req_%0d", k), bus.mem_req, mreq_tab[k]);
      chk($sformatf("t4_gnt_%0d", k), bus.s_gnt, mreq_tab[k] ? 3'b001 : 3'b000);
      if (mreq_tab[k]) n++;
    end
    step(); bus.s_req = '0;
    drain("t4_drain");

    // unexpected response
    step(); inj_valid = 1'b1; inj_err = 1'b1; inj_rdata = 32'hDEAD_BEEF;
    settle(); chk("t5_rsp_valid", bus.s_rsp_valid, 3'b000); chk("t5_err_pre", err_unexp_rsp, 1'b0);
    chk("t5_rsp_error", bus.s_rsp_error, 1'b1);
    step(); inj_valid = 1'b0; inj_err = 1'b0;
    settle(); chk("t5_err_set", err_unexp_rsp, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(); settle(); chk($sformatf("t5_err_hold_%0d", k), err_unexp_rsp, 1'b1);
    end
    step(); aresetn = 1'b0; #1;
    chk("t5_err_cleared", err_unexp_rsp, 1'b0);
    step(); aresetn = 1'b1;

    // mid-operation reset, then end-to-end image write/read
    mem_lat = 8;
    for (int k = 0; k < 3; k++) begin
      step(); bus.s_req = 3'b001; bus.mem_gnt = 1'b1;
      drive_req(0, 32'h0000_3000 + 32'(4*k), 1'b0, '0, 4'hF);
    end
    step(); bus.s_req = '0;
    settle(); chk("t6_busy_outstanding", busy, 1'b1);
    step(); aresetn = 1'b0;
    settle(); chk("t6_busy_reset", busy, 1'b0); chk("t6_err_reset", err_unexp_rsp, 1'b0);
    step(); aresetn = 1'b1;
    mem_lat = 3; bus.mem_gnt = 1'b1;
    xfer(1'b1, "t6_wr");
    xfer(1'b0, "t6_rd");
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
